// File: rtl/rr_arb2.sv
// Two-source round-robin arbiter with packet lock and a registered output stage.
// Only a_ready and b_ready are combinational. Every other output comes from a register.
module rr_arb2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             y_valid,
   output logic [WIDTH-1:0] y_data,
   output logic             y_last,
   output logic             sel,
   input  logic             y_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   last_b;
   logic   load;
   logic   grant_a;
   logic   grant_b;
   logic   a_xfer;
   logic   b_xfer;

   // Grant selection; on contention in IDLE the source not served last wins
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      case (state)
         IDLE: begin
            if (a_valid && b_valid) begin
               grant_a = last_b;
               grant_b = !last_b;
            end else begin
               grant_a = a_valid;
               grant_b = b_valid;
            end
         end
         LOCK_A:  grant_a = 1'b1;
         LOCK_B:  grant_b = 1'b1;
         default: begin
            grant_a = 1'b0;
            grant_b = 1'b0;
         end
      endcase
   end

   assign load    = !y_valid || y_ready;
   assign a_ready = rst_n && load && grant_a;
   assign b_ready = rst_n && load && grant_b;
   assign a_xfer  = a_valid && a_ready;
   assign b_xfer  = b_valid && b_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a beat without last locks its source, a last beat releases it
   always_comb begin
      state_nxt = state;
      if (a_xfer) begin
         state_nxt = a_last ? IDLE : LOCK_A;
      end else if (b_xfer) begin
         state_nxt = b_last ? IDLE : LOCK_B;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_last  <= 1'b0;
         sel     <= 1'b0;
         last_b  <= 1'b1;
      end else if (load) begin
         if (a_xfer) begin
            y_valid <= 1'b1;
            y_data  <= a_data;
            y_last  <= a_last;
            sel     <= 1'b0;
            last_b  <= 1'b0;
         end else if (b_xfer) begin
            y_valid <= 1'b1;
            y_data  <= b_data;
            y_last  <= b_last;
            sel     <= 1'b1;
            last_b  <= 1'b1;
         end else begin
            y_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rr_arb2.md
RR_ARB2 -- requirements
Module: rr_arb2

Interface
REQ-001 Parameter WIDTH, default 8, gives the data width of both inputs and the output.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset; assertion clears state immediately, release is synchronous to clk.
REQ-004 a_valid  input  1  Source A offers a beat.
REQ-005 a_data  input  WIDTH  Source A payload.
REQ-006 a_last  input  1  Source A beat ends a packet.
REQ-007 a_ready  output  1  Source A beat accepted this cycle.
REQ-008 b_valid, b_data, b_last, b_ready have the same directions, widths and meanings for source B.
REQ-009 y_valid  output  1  Output beat held in the output register.
REQ-010 y_data  output  WIDTH  Output payload, registered.
REQ-011 y_last  output  1  Output beat ends a packet, registered.
REQ-012 sel  output  1  Source of the current output beat: 0 = A, 1 = B, registered; it matches the select of the downstream 2:1 mux.
REQ-013 y_ready  input  1  Consumer accepts the output beat this cycle.

Function
REQ-014 Handshake: a transfer occurs on any port in a cycle where valid and ready are both 1.
REQ-015 load = !y_valid || y_ready; the output register accepts a new beat only when load = 1.
REQ-016 State machine states: IDLE, LOCK_A, LOCK_B.
REQ-017 IDLE grant: only a_valid -> A; only b_valid -> B; both -> the source not recorded in the round-robin pointer last; neither -> no grant.
REQ-018 LOCK_A grants only A; LOCK_B grants only B; the other source sees ready = 0 regardless of its valid.
REQ-019 a_ready = load && grant==A; b_ready = load && grant==B; at most one ready is 1 per cycle.
REQ-020 On a transfer from source X: y_data, y_last and sel capture X's data, last and id; y_valid becomes 1; last <= X.
REQ-021 State transitions on a transfer from X: X_last = 0 -> LOCK_X; X_last = 1 -> IDLE. With no transfer, the state holds.
REQ-022 Packet lock: a source holds the grant from its first beat until its last=1 beat transfers, even if the other source is waiting.
REQ-023 Single-beat packet (last = 1 on the first beat): the FSM stays in IDLE and the round-robin pointer still updates.
REQ-024 If y_ready = 1 and no input transfers, y_valid goes to 0 next cycle.
REQ-025 Latency: a beat accepted in cycle N appears on y_* in cycle N+1.
REQ-026 Throughput: 1 beat/cycle sustained when y_ready is held at 1.
REQ-027 Stall: while y_valid && !y_ready, y_data, y_last and sel hold stable and both readies are 0.
REQ-028 In LOCK_X, a_valid/b_valid gaps (X_valid = 0) hold the lock; no beat from the other source is interleaved.
REQ-029 Simultaneous output drain and input load in the same cycle replaces the output beat with no bubble.
REQ-030 Readies are combinational from valids, state and y_ready; no other outputs are combinational.

Reset
REQ-031 While rst_n = 0: state = IDLE, y_valid = 0, y_data = 0, y_last = 0, sel = 0, last = B (so A wins the first contention), a_ready = 0, b_ready = 0.
REQ-032 Reset asserted mid-packet or mid-stall discards the held beat and the lock; no beat is emitted after release until a new transfer occurs.

Verification
REQ-033 Alternating contention: a_valid = b_valid = 1, all last = 1, y_ready = 1, a_data = 8'hA0+i, b_data = 8'hB0+i -> y_data sequence A0, B0, A1, B1, ..., with sel toggling 0, 1, 0, 1.
REQ-034 Packet lock: A sends a 3-beat packet (last on beat 3) while b_valid = 1 throughout -> three A beats with sel = 0, then B is granted; b_ready = 0 during the A packet.
REQ-035 Backpressure: y_ready = 0 for 4 cycles with a beat held -> y_data/sel stable, a_ready = b_ready = 0; on release, the next beat follows with no loss or duplication.
REQ-036 Single source: only b_valid = 1, last = 1, y_ready = 1 for 5 beats -> 5 consecutive outputs, sel = 1, one beat per cycle, latency 1.
REQ-037 Reset in LOCK_A after beat 2 of 4: rst_n pulsed low -> y_valid = 0 immediately; after release, with both sources valid, A is granted first.
REQ-038 Scoreboard: per-source packet order and content is preserved, with no interleaving inside a packet, over 10k randomized valid/ready/last cycles.
